// File: rtl/stack_pkg.sv
// Shared types and sizing helpers for the LIFO stack: the operation encoding
// and the count/address width functions.
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_REPLACE = 3'd3,
        OP_CLEAR   = 3'd4
    } stack_op_e;

    // Occupancy needs to represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int addr_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/lifo_stack_if.sv
// Control, data and status bundle of the LIFO stack.
interface lifo_stack_if
    import stack_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = cnt_width(DEPTH);

    logic             clear_i;
    logic             push_i;
    logic             pop_i;
    logic [WIDTH-1:0] data_in_i;
    logic [WIDTH-1:0] data_out_o;
    logic [CW-1:0]    count_o;
    logic             full_o;
    logic             empty_o;
    logic             almost_full_o;
    logic             overflow_o;
    logic             underflow_o;

    modport master (
        output clear_i, push_i, pop_i, data_in_i,
        input  data_out_o, count_o, full_o, empty_o, almost_full_o,
               overflow_o, underflow_o
    );

    modport slave (
        input  clear_i, push_i, pop_i, data_in_i,
        output data_out_o, count_o, full_o, empty_o, almost_full_o,
               overflow_o, underflow_o
    );

endinterface

// File: rtl/stack_mem.sv
// Stack storage: register array with one synchronous write port and one
// asynchronous read port; contents are deliberately not reset.
module stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack top: operation decoder, occupancy register, registered error
// pulses and combinational status flags around the stack_mem storage.
module lifo_stack
    import stack_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    lifo_stack_if.slave bus
);

    localparam int CW = cnt_width(DEPTH);
    localparam int AW = addr_width(DEPTH);

    stack_op_e        op_s;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             empty_s, full_s;
    logic [CW-1:0]    top_full_s;
    logic [AW-1:0]    top_idx_s;
    logic [AW-1:0]    raddr_s;
    logic [AW-1:0]    waddr_s;
    logic             we_s;
    logic [WIDTH-1:0] rdata_s;

    assign empty_s    = (count_q == {CW{1'b0}});
    assign full_s     = (count_q == CW'(DEPTH));
    assign top_full_s = count_q - CW'(1);
    assign top_idx_s  = top_full_s[AW-1:0];
    assign raddr_s    = empty_s ? {AW{1'b0}} : top_idx_s;

    // Operation decode: CLEAR wins, PUSH+POP on an empty stack is a plain push
    always_comb begin
        op_s  = OP_NONE;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (bus.clear_i) begin
            op_s = OP_CLEAR;
        end else if (bus.push_i && bus.pop_i) begin
            op_s = empty_s ? OP_PUSH : OP_REPLACE;
        end else if (bus.push_i) begin
            if (full_s) begin
                ovf_d = 1'b1;
            end else begin
                op_s = OP_PUSH;
            end
        end else if (bus.pop_i) begin
            if (empty_s) begin
                unf_d = 1'b1;
            end else begin
                op_s = OP_POP;
            end
        end else begin
            op_s = OP_NONE;
        end
    end

    // Next occupancy and storage write control
    always_comb begin
        count_d = count_q;
        we_s    = 1'b0;
        waddr_s = {AW{1'b0}};
        case (op_s)
            OP_PUSH: begin
                count_d = count_q + CW'(1);
                we_s    = 1'b1;
                waddr_s = count_q[AW-1:0];
            end
            OP_POP: begin
                count_d = count_q - CW'(1);
            end
            OP_REPLACE: begin
                we_s    = 1'b1;
                waddr_s = top_idx_s;
            end
            OP_CLEAR: begin
                count_d = {CW{1'b0}};
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Occupancy and error-pulse registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= {CW{1'b0}};
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (we_s),
        .waddr_i (waddr_s),
        .wdata_i (bus.data_in_i),
        .raddr_i (raddr_s),
        .rdata_o (rdata_s)
    );

    assign bus.data_out_o    = empty_s ? {WIDTH{1'b0}} : rdata_s;
    assign bus.count_o       = count_q;
    assign bus.full_o        = full_s;
    assign bus.empty_o       = empty_s;
    assign bus.almost_full_o = (count_q >= CW'(AF_LEVEL));
    assign bus.overflow_o    = ovf_q;
    assign bus.underflow_o   = unf_q;

endmodule
